// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Contents: stall-vector bit indices, stall patterns, FSM state encoding.
package pipe_ctrl_pkg;

    // Stall-vector bit positions, upstream to downstream
    localparam int unsigned STALL_PC    = 0;
    localparam int unsigned STALL_IFID  = 1;
    localparam int unsigned STALL_IDEX  = 2;
    localparam int unsigned STALL_EXMEM = 3;
    localparam int unsigned STALL_MEMWB = 4;
    localparam int unsigned STALL_WB    = STALL_MEMWB + 1;
    localparam int unsigned STALL_W     = STALL_WB + 1;

    // Hold patterns: a stall freezes its source stage and everything upstream
    localparam logic [STALL_W-1:0] STALL_NONE = '0;
    localparam logic [STALL_W-1:0] STALL_ID   =
        STALL_W'((1 << STALL_PC) | (1 << STALL_IFID) | (1 << STALL_IDEX));
    localparam logic [STALL_W-1:0] STALL_EX   = STALL_ID | STALL_W'(1 << STALL_EXMEM);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Consecutive-stall watchdog with a sticky timeout flag.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall_active_i    pipeline is stalled this cycle
//   flush_i           pipeline is flushing this cycle (restarts the count)
//   timeout_o         sticky: MAX_STALL consecutive stalled cycles seen
module pipe_ctrl_wdog #(
    parameter int unsigned MAX_STALL = 256,
    parameter int unsigned WD_W      = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active_i,
    input  logic flush_i,
    output logic timeout_o
);

    logic [WD_W-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    // Count runs of stalled cycles, saturating at the threshold
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (flush_i || !stall_active_i) begin
            cnt_d = '0;
        end else if (cnt_q != WD_W'(MAX_STALL)) begin
            cnt_d = cnt_q + WD_W'(1);
        end
        // Flag sets on the edge that closes the MAX_STALL-th stalled cycle
        if (cnt_d == WD_W'(MAX_STALL)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall arbitration, multi-cycle EX timing,
// flush sequencing with redirect PC, and a stall watchdog.
// Optional build macro: PIPE_CTRL_PERF_EN adds stall/flush performance counters.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_stallreq_id/ex    level stall requests from ID and EX
//   i_mc_start          pulse: EX starts a multi-cycle op of i_mc_cycles cycles
//   i_flush_req         pulse: redirect to i_flush_pc
//   o_stall             per-stage hold vector (combinational)
//   o_flush, o_new_pc   flush strobe and redirect PC
//   o_mc_busy/done      multi-cycle op in progress / final cycle
//   o_perf_*            (PIPE_CTRL_PERF_EN only) stall and flush cycle counters
//   o_stall_timeout     sticky watchdog flag
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_CNT_W  = 6,
    parameter int unsigned MAX_STALL = 256,
    parameter int unsigned WD_W      = 9
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int unsigned PERF_W    = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_stallreq_id,
    input  logic                i_stallreq_ex,
    input  logic                i_mc_start,
    input  logic [MC_CNT_W-1:0] i_mc_cycles,
    input  logic                i_flush_req,
    input  logic [31:0]         i_flush_pc,
    output logic [STALL_W-1:0]  o_stall,
    output logic                o_flush,
    output logic [31:0]         o_new_pc,
    output logic                o_mc_busy,
    output logic                o_mc_done,
`ifdef PIPE_CTRL_PERF_EN
    output logic [PERF_W-1:0]   o_perf_stall_cnt,
    output logic [PERF_W-1:0]   o_perf_flush_cnt,
`endif
    output logic                o_stall_timeout
);

    state_e              state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]         pc_q, pc_d;

    logic                mc_accept_c;
    logic                mc_short_c;
    logic [STALL_W-1:0]  stall_c;
    logic                flush_c;
    logic                busy_c;
    logic                done_c;

    // A start competes with a same-cycle flush and loses
    assign mc_accept_c = (state_q == ST_IDLE) && i_mc_start && !i_flush_req;
    // Lengths 0 and 1 both complete in the start cycle
    assign mc_short_c  = (i_mc_cycles <= MC_CNT_W'(1));

    // Next-state, countdown and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        stall_c = STALL_NONE;
        flush_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mc_accept_c) begin
                    busy_c = 1'b1;
                    if (mc_short_c) begin
                        done_c = 1'b1;
                    end else begin
                        // Start cycle counts as the first stalled cycle
                        cnt_d   = i_mc_cycles - MC_CNT_W'(1);
                        state_d = ST_MC_BUSY;
                    end
                end
            end
            ST_MC_BUSY: begin
                busy_c = 1'b1;
                if (cnt_q == MC_CNT_W'(1)) begin
                    done_c  = !i_flush_req;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - MC_CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                flush_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush request from any state wins, aborting any op in flight
        if (i_flush_req) begin
            pc_d    = i_flush_pc;
            cnt_d   = '0;
            state_d = ST_FLUSH;
        end

        // Priority: FLUSH > EX > ID
        if (state_q == ST_FLUSH) begin
            stall_c = STALL_NONE;
        end else if (i_stallreq_ex || busy_c) begin
            stall_c = STALL_EX;
        end else if (i_stallreq_id) begin
            stall_c = STALL_ID;
        end

        // Hold every strobe quiet while reset is asserted
        if (rst) begin
            stall_c = STALL_NONE;
            flush_c = 1'b0;
            busy_c  = 1'b0;
            done_c  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    pipe_ctrl_wdog #(
        .MAX_STALL (MAX_STALL),
        .WD_W      (WD_W)
    ) u_wdog (
        .clk            (clk),
        .rst            (rst),
        .stall_active_i (stall_c != STALL_NONE),
        .flush_i        (flush_c),
        .timeout_o      (o_stall_timeout)
    );

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_flush_q;

    // Free-running event counters, wrap on overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_c != STALL_NONE) perf_stall_q <= perf_stall_q + PERF_W'(1);
            if (flush_c)               perf_flush_q <= perf_flush_q + PERF_W'(1);
        end
    end

    assign o_perf_stall_cnt = perf_stall_q;
    assign o_perf_flush_cnt = perf_flush_q;
`endif

    assign o_stall   = stall_c;
    assign o_flush   = flush_c;
    assign o_new_pc  = pc_q;
    assign o_mc_busy = busy_c;
    assign o_mc_done = done_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic,
// checked every cycle against a cycle-count reference model via a scoreboard.
module tb_pipe_ctrl;

    localparam int MC_W      = 6;
    localparam int MAX_STALL = 256;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            stallreq_id = 1'b0;
    logic            stallreq_ex = 1'b0;
    logic            mc_start = 1'b0;
    logic [MC_W-1:0] mc_cycles = '0;
    logic            flush_req = 1'b0;
    logic [31:0]     flush_pc = '0;

    logic [5:0]      stall;
    logic            flush;
    logic [31:0]     new_pc;
    logic            mc_busy;
    logic            mc_done;
    logic            timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]     perf_stall;
    logic [31:0]     perf_flush;
`endif

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .i_stallreq_id   (stallreq_id),
        .i_stallreq_ex   (stallreq_ex),
        .i_mc_start      (mc_start),
        .i_mc_cycles     (mc_cycles),
        .i_flush_req     (flush_req),
        .i_flush_pc      (flush_pc),
        .o_stall         (stall),
        .o_flush         (flush),
        .o_new_pc        (new_pc),
        .o_mc_busy       (mc_busy),
        .o_mc_done       (mc_done),
`ifdef PIPE_CTRL_PERF_EN
        .o_perf_stall_cnt(perf_stall),
        .o_perf_flush_cnt(perf_flush),
`endif
        .o_stall_timeout (timeout)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
        logic        done;
        logic        to;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state: pending flush, op cycles still to run,
    // length of the current stall run, sticky timeout, event tallies
    bit          m_in_flush = 1'b0;
    logic [31:0] m_pc       = '0;
    int          m_left     = 0;
    int          m_run      = 0;
    bit          m_to       = 1'b0;
    logic [31:0] m_ps       = '0;
    logic [31:0] m_pf       = '0;

    task automatic model_cycle(input bit r, input bit sid, input bit sex, input bit mcs,
                               input int mcn, input bit fr, input logic [31:0] fpc);
        exp_t e;
        int   left;
        bit   busy;
        e.pc = m_pc;
        e.to = m_to;
        e.ps = m_ps;
        e.pf = m_pf;
        if (r) begin
            e.stall = 6'b000000;
            e.flush = 1'b0;
            e.busy  = 1'b0;
            e.done  = 1'b0;
            m_in_flush = 1'b0; m_pc = '0; m_left = 0; m_run = 0; m_to = 1'b0;
            m_ps = '0; m_pf = '0;
        end else begin
            left = m_left;
            if (!m_in_flush && left == 0 && mcs && !fr) left = (mcn < 1) ? 1 : mcn;
            busy    = !m_in_flush && (left > 0);
            e.flush = m_in_flush;
            e.busy  = busy;
            e.done  = busy && (left == 1) && !fr;
            if (m_in_flush)       e.stall = 6'b000000;
            else if (sex || busy) e.stall = 6'b001111;
            else if (sid)         e.stall = 6'b000111;
            else                  e.stall = 6'b000000;
            if (e.stall != 0 && !e.flush) begin
                if (m_run < MAX_STALL) m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run == MAX_STALL) m_to = 1'b1;
            if (e.stall != 0) m_ps = m_ps + 1;
            if (e.flush)      m_pf = m_pf + 1;
            m_left = busy ? left - 1 : 0;
            if (fr) begin
                m_left     = 0;
                m_in_flush = 1'b1;
                m_pc       = fpc;
            end else begin
                m_in_flush = 1'b0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit sid, input bit sex, input bit mcs,
                         input int mcn, input bit fr, input logic [31:0] fpc);
        @(posedge clk);
        #1;
        rst         = r;
        stallreq_id = sid;
        stallreq_ex = sex;
        mc_start    = mcs;
        mc_cycles   = MC_W'(mcn);
        flush_req   = fr;
        flush_pc    = fpc;
        model_cycle(r, sid, sex, mcs, mcn, fr, fpc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle
    exp_t m_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            chk("stall",   32'(stall),   32'(m_e.stall));
            chk("flush",   32'(flush),   32'(m_e.flush));
            chk("new_pc",  new_pc,       m_e.pc);
            chk("mc_busy", 32'(mc_busy), 32'(m_e.busy));
            chk("mc_done", 32'(mc_done), 32'(m_e.done));
            chk("timeout", 32'(timeout), 32'(m_e.to));
`ifdef PIPE_CTRL_PERF_EN
            chk("perf_stall", perf_stall, m_e.ps);
            chk("perf_flush", perf_flush, m_e.pf);
`endif
            cyc++;
        end
    end

    initial begin
        // Reset
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);

        // ID stalls, then EX joins and wins
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0, 32'h0);
        drive(0, 1, 1, 0, 0, 0, 32'h0);
        idle(3);

        // Five-cycle op
        drive(0, 0, 0, 1, 5, 0, 32'h0);
        idle(6);

        // Degenerate lengths 0 and 1
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        idle(2);
        drive(0, 0, 0, 1, 1, 0, 32'h0);
        idle(2);

        // Op aborted by a flush
        drive(0, 0, 0, 1, 20, 0, 32'h0);
        idle(5);
        drive(0, 0, 0, 0, 0, 1, 32'hBFC0_0380);
        idle(3);

        // Back-to-back flushes
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0100);
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0200);
        idle(3);

        // Start coinciding with a flush is dropped; start during an op is ignored
        drive(0, 0, 0, 1, 4, 1, 32'h0000_0300);
        idle(2);
        drive(0, 0, 0, 1, 3, 0, 32'h0);
        drive(0, 0, 0, 1, 9, 0, 32'h0);
        idle(4);

        // Flush on the final op cycle suppresses done
        drive(0, 0, 0, 1, 3, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0400);
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(0,
                  ($urandom_range(99) < 15),
                  ($urandom_range(99) < 8),
                  ($urandom_range(99) < 10),
                  int'($urandom_range(12)),
                  ($urandom_range(99) < 6),
                  $urandom);
        end

        // Watchdog: long EX stall, drop, resume, reset mid-stall
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        idle(2);
        for (int i = 0; i < 260; i++) drive(0, 0, 1, 0, 0, 0, 32'h0);
        idle(3);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 0, 32'h0);
        drive(1, 0, 1, 0, 0, 0, 32'h0);
        drive(0, 0, 1, 0, 0, 0, 32'h0);
        drive(0, 0, 1, 0, 0, 0, 32'h0);
        idle(3);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
